stopwatch_core: RTL

Parametrised MM:SS BCD stopwatch/timer core. It counts up or down on a 1 Hz tick, and pauses and resumes on a pulse. Manual adjust steps either field on a 2 Hz tick, and the core also supports parallel load, lap capture and terminal detection. It sits between the clock-divider tick generators and the seven-segment display driver, replacing the fixed 59:59 count-up-only counter.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_if.sv | 31 +++
 rtl/stopwatch_core_bcd_field.sv | 54 +++++
 rtl/stopwatch_core.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
// Helpers convert a two-digit BCD field to binary and back.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int BCD_W   = 16;

    function automatic logic [6:0] bcd2bin(input bcd_t tens, input bcd_t ones);
        return {3'b000, tens} * 7'd10 + {3'b000, ones};
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
        logic [6:0] tens;
        tens = bin / 7'd10;
        return {4'(tens), 4'(bin - tens * 7'd10)};
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control/status bundle between the tick dividers, the stopwatch core and the display driver.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic             run_tick;
    logic             adj_tick;
    logic             pause;
    logic             adj;
    logic             sel;
    logic             dir;
    logic             load;
    logic [BCD_W-1:0] load_bcd;
    logic             lap;
    logic [BCD_W-1:0] count_bcd;
    logic [BCD_W-1:0] lap_bcd;
    logic             lap_valid;
    logic             running;
    logic             done;
    logic             load_err;

    modport master (
        output run_tick, adj_tick, pause, adj, sel, dir, load, load_bcd, lap,
        input  count_bcd, lap_bcd, lap_valid, running, done, load_err
    );

    modport slave (
        input  run_tick, adj_tick, pause, adj, sel, dir, load, load_bcd, lap,
        output count_bcd, lap_bcd, lap_valid, running, done, load_err
    );

endinterface

// File: rtl/stopwatch_core_bcd_field.sv
// Two-digit BCD register wrapping at MAX; supports +1, -1, +STEP (mod MAX+1) and parallel load.
// carry/borrow flag the wrap so a higher field can follow.
module bcd_field
    import stopwatch_pkg::*;
#(
    parameter int MAX  = 59,
    parameter int STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       add,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic [7:0] nxt,
    output logic       carry,
    output logic       borrow
);

    localparam logic [6:0] MAX_B  = 7'(MAX);
    localparam logic [6:0] MOD_B  = 7'(MAX + 1);
    localparam logic [6:0] STEP_B = 7'(STEP);

    logic [6:0] bin;
    logic [6:0] bin_nxt;

    assign bin = bcd2bin(value[7:4], value[3:0]);

    always_comb begin
        bin_nxt = bin;
        if (add) begin
            bin_nxt = (bin + STEP_B) % MOD_B;
        end else if (up) begin
            bin_nxt = (bin == MAX_B) ? 7'd0 : bin + 7'd1;
        end else if (down) begin
            bin_nxt = (bin == 7'd0) ? MAX_B : bin - 7'd1;
        end
    end

    assign nxt    = load ? load_val : bin2bcd(bin_nxt);
    assign carry  = up && (bin == MAX_B);
    assign borrow = down && (bin == 7'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 8'h00;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch/timer: tick edge detect, run/pause/done FSM, load check and lap capture.
//
//  state  | meaning
//  PAUSED | count frozen, waiting for pause pulse to start
//  RUN    | count steps on each run_tick edge (unless adj held)
//  DONE   | terminal value reached; left only by load or adjust step
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX  = 59,
    parameter int ADJ_STEP = 2
) (
    input  logic       clk,
    input  logic       rst,
    stopwatch_if.slave bus
);

    localparam logic [7:0]       MIN_TERM = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
    localparam logic [7:0]       SEC_TERM = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};
    localparam logic [BCD_W-1:0] UP_TERM  = {MIN_TERM, SEC_TERM};

    state_t           state;
    state_t           state_nxt;
    logic             run_prev;
    logic             adj_prev;
    logic             run_edge;
    logic             adj_edge;
    logic [7:0]       sec_val;
    logic [7:0]       min_val;
    logic [7:0]       sec_nxt;
    logic [7:0]       min_nxt;
    logic             sec_carry;
    logic             sec_borrow;
    logic             min_carry;
    logic             min_borrow;
    logic             unused_min_wrap;
    logic             load_ok;
    logic             load_acc;
    logic             adj_step;
    logic             cnt_step;
    logic             cnt_move;
    logic [BCD_W-1:0] term_val;
    logic             at_term;
    logic             hits_term;
    logic             running_q;
    logic             done_q;
    logic [BCD_W-1:0] lap_q;
    logic             lap_valid_q;
    logic             load_err_q;

    // Edges are registered, so a tick reaches the count two cycles after it rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_prev <= 1'b0;
            adj_prev <= 1'b0;
            run_edge <= 1'b0;
            adj_edge <= 1'b0;
        end else begin
            run_prev <= bus.run_tick;
            adj_prev <= bus.adj_tick;
            run_edge <= bus.run_tick & ~run_prev;
            adj_edge <= bus.adj_tick & ~adj_prev;
        end
    end

    always_comb begin
        load_ok = (bus.load_bcd[15:12] <= 4'd9) && (bus.load_bcd[11:8] <= 4'd9) &&
                  (bus.load_bcd[7:4] <= 4'd5) && (bus.load_bcd[3:0] <= 4'd9) &&
                  (bcd2bin(bus.load_bcd[15:12], bus.load_bcd[11:8]) <= 7'(MIN_MAX));
    end

    assign load_acc  = bus.load & load_ok;
    assign adj_step  = adj_edge & bus.adj & ~bus.load;
    assign cnt_step  = run_edge & (state == RUN) & ~bus.adj & ~bus.load;
    assign term_val  = bus.dir ? '0 : UP_TERM;
    assign at_term   = ({min_val, sec_val} == term_val);
    assign cnt_move  = cnt_step & ~at_term;
    assign hits_term = cnt_step && ({min_nxt, sec_nxt} == term_val);

    bcd_field #(.MAX(SEC_MAX), .STEP(ADJ_STEP)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .up       (cnt_move & ~bus.dir),
        .down     (cnt_move & bus.dir),
        .add      (adj_step & bus.sel),
        .load     (load_acc),
        .load_val (bus.load_bcd[7:0]),
        .value    (sec_val),
        .nxt      (sec_nxt),
        .carry    (sec_carry),
        .borrow   (sec_borrow)
    );

    bcd_field #(.MAX(MIN_MAX), .STEP(ADJ_STEP)) u_min (
        .clk      (clk),
        .rst      (rst),
        .up       (sec_carry),
        .down     (sec_borrow),
        .add      (adj_step & ~bus.sel),
        .load     (load_acc),
        .load_val (bus.load_bcd[15:8]),
        .value    (min_val),
        .nxt      (min_nxt),
        .carry    (min_carry),
        .borrow   (min_borrow)
    );

    // Minutes never wrap: counting stops at the terminal value first.
    assign unused_min_wrap = min_carry | min_borrow;

    always_comb begin
        state_nxt = state;
        if (bus.load) begin
            if (load_ok) begin
                state_nxt = PAUSED;
            end
        end else begin
            case (state)
                PAUSED: if (bus.pause) state_nxt = RUN;
                RUN: begin
                    if (hits_term) begin
                        state_nxt = DONE;
                    end else if (bus.pause) begin
                        state_nxt = PAUSED;
                    end
                end
                DONE: if (adj_step) state_nxt = PAUSED;
                default: state_nxt = PAUSED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PAUSED;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            running_q <= (state_nxt == RUN);
            done_q    <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            if (bus.lap) begin
                lap_q       <= {min_val, sec_val};
                lap_valid_q <= 1'b1;
            end
            load_err_q <= bus.load & ~load_ok;
        end
    end

    assign bus.count_bcd = {min_val, sec_val};
    assign bus.lap_bcd   = lap_q;
    assign bus.lap_valid = lap_valid_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.load_err  = load_err_q;

endmodule
